// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, ALU op
// encodings, T-state numbers and the control word that the microcode
// decoder produces.
package cpu_pkg;

  // Instruction opcodes (IR[7:4]); 11..13 are undefined
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // ALU operation select, shared with the ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_SRL = 2'b11;

  // T-state numbers; callers size them to their step counter width
  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 1;
  localparam int unsigned T2 = 2;
  localparam int unsigned T3 = 3;
  localparam int unsigned T4 = 4;

  // One microinstruction worth of datapath control lines.
  // flags_load never leaves the control unit; it strobes the flag register.
  typedef struct packed {
    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ram_in;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic       out_load;
    logic       flags_load;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // True for step values the sequencer can legally reach from reset
  function automatic logic step_is_legal(input int unsigned s);
    return (s <= T4);
  endfunction

endpackage : cpu_pkg

// File: rtl/cpu_control_unit_if.sv
// Bundle of run/opcode/ALU-status inputs and datapath control outputs of
// the CPU control unit. master = control unit side, slave = datapath side.
interface cpu_control_unit_if #(
  parameter int StepBits = 3
);

  logic                enable;
  logic [3:0]          opcode;
  logic                alu_carry;
  logic                alu_zero;

  logic                pc_out;
  logic                pc_inc;
  logic                pc_load;
  logic                mar_load;
  logic                ram_out;
  logic                ram_in;
  logic                ir_load;
  logic                ir_out;
  logic                a_load;
  logic                a_out;
  logic                b_load;
  logic                alu_out;
  logic [1:0]          alu_op;
  logic                out_load;
  logic                flag_carry;
  logic                flag_zero;
  logic                halted;
  logic [StepBits-1:0] step;

  modport master (
    input  enable, opcode, alu_carry, alu_zero,
    output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load,
           ir_out, a_load, a_out, b_load, alu_out, alu_op, out_load,
           flag_carry, flag_zero, halted, step
  );

  modport slave (
    output enable, opcode, alu_carry, alu_zero,
    input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load,
           ir_out, a_load, a_out, b_load, alu_out, alu_op, out_load,
           flag_carry, flag_zero, halted, step
  );

endinterface : cpu_control_unit_if

// File: rtl/cpu_control_decode.sv
// Microcode ROM of the CPU written as combinational logic: maps the current
// T-state, opcode and flags to a control word, an end-of-instruction bit and
// a halt request. No state lives here.
module cpu_control_decode
  import cpu_pkg::*;
#(
  parameter int StepBits        = 3,
  parameter bit HaltOnUndefined = 1'b0
) (
  input  logic [StepBits-1:0] step_i,
  input  logic [3:0]          opcode_i,
  input  logic                flag_carry_i,
  input  logic                flag_zero_i,
  output ctrl_t               ctrl_o,
  output logic                end_o,
  output logic                halt_o
);

  // Microinstruction lookup by T-state, then by opcode once past fetch
  always_comb begin
    ctrl_o = CTRL_NONE;
    end_o  = 1'b0;
    halt_o = 1'b0;

    case (step_i)
      StepBits'(T0): begin
        ctrl_o.pc_out   = 1'b1;
        ctrl_o.mar_load = 1'b1;
      end

      StepBits'(T1): begin
        ctrl_o.ram_out = 1'b1;
        ctrl_o.ir_load = 1'b1;
        ctrl_o.pc_inc  = 1'b1;
      end

      StepBits'(T2): begin
        case (opcode_i)
          OP_NOP: end_o = 1'b1;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            // Operand address from IR low nibble into MAR
            ctrl_o.ir_out   = 1'b1;
            ctrl_o.mar_load = 1'b1;
          end
          OP_LDI: begin
            ctrl_o.ir_out = 1'b1;
            ctrl_o.a_load = 1'b1;
            end_o         = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.ir_out  = 1'b1;
            ctrl_o.pc_load = 1'b1;
            end_o          = 1'b1;
          end
          OP_JC: begin
            ctrl_o.ir_out  = 1'b1;
            ctrl_o.pc_load = flag_carry_i;
            end_o          = 1'b1;
          end
          OP_JZ: begin
            ctrl_o.ir_out  = 1'b1;
            ctrl_o.pc_load = flag_zero_i;
            end_o          = 1'b1;
          end
          OP_SHL: begin
            ctrl_o.alu_out    = 1'b1;
            ctrl_o.a_load     = 1'b1;
            ctrl_o.flags_load = 1'b1;
            ctrl_o.alu_op     = ALU_SLL;
            end_o             = 1'b1;
          end
          OP_SHR: begin
            ctrl_o.alu_out    = 1'b1;
            ctrl_o.a_load     = 1'b1;
            ctrl_o.flags_load = 1'b1;
            ctrl_o.alu_op     = ALU_SRL;
            end_o             = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.a_out    = 1'b1;
            ctrl_o.out_load = 1'b1;
            end_o           = 1'b1;
          end
          OP_HLT: begin
            halt_o = 1'b1;
            end_o  = 1'b1;
          end
          default: begin
            // Undefined opcodes: either a NOP or a HLT, chosen at build time
            halt_o = HaltOnUndefined;
            end_o  = 1'b1;
          end
        endcase
      end

      StepBits'(T3): begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.ram_out = 1'b1;
            ctrl_o.a_load  = 1'b1;
            end_o          = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.ram_out = 1'b1;
            ctrl_o.b_load  = 1'b1;
          end
          OP_STA: begin
            ctrl_o.a_out  = 1'b1;
            ctrl_o.ram_in = 1'b1;
            end_o         = 1'b1;
          end
          // Only reachable if the opcode changes mid-instruction: recover to fetch
          default: end_o = 1'b1;
        endcase
      end

      StepBits'(T4): begin
        case (opcode_i)
          OP_ADD, OP_SUB: begin
            ctrl_o.alu_out    = 1'b1;
            ctrl_o.a_load     = 1'b1;
            ctrl_o.flags_load = 1'b1;
            ctrl_o.alu_op     = (opcode_i == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
          default: ;
        endcase
        // T4 is always the last state
        end_o = 1'b1;
      end

      default: ;
    endcase
  end

endmodule : cpu_control_decode

// File: rtl/cpu_control_unit.sv
// CPU control unit: owns the T-state counter, the carry/zero flag register
// and the halt latch, and gates the decoded control word onto the datapath.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int StepBits        = 3,
  parameter bit HaltOnUndefined = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_unit_if.master bus
);

  logic [StepBits-1:0] step_q, step_d;
  logic                halted_q, halted_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;

  ctrl_t dec_ctrl;
  ctrl_t out_ctrl;
  logic  dec_end;
  logic  dec_halt;
  logic  step_legal;
  logic  run;

  cpu_control_decode #(
    .StepBits        (StepBits),
    .HaltOnUndefined (HaltOnUndefined)
  ) u_decode (
    .step_i       (step_q),
    .opcode_i     (bus.opcode),
    .flag_carry_i (carry_q),
    .flag_zero_i  (zero_q),
    .ctrl_o       (dec_ctrl),
    .end_o        (dec_end),
    .halt_o       (dec_halt)
  );

  assign step_legal = step_is_legal(32'(step_q));

  // The sequencer advances only when enabled, not halted and not in reset
  assign run = bus.enable && !halted_q && !reset;

  // Next-state: step advance/wrap, halt entry, flag capture
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    if (!step_legal) begin
      // Unreachable step value: fall back to fetch regardless of enable
      step_d = '0;
    end else if (run) begin
      if (dec_halt) begin
        halted_d = 1'b1;
        step_d   = '0;
      end else if (dec_end) begin
        step_d = '0;
      end else begin
        step_d = step_q + StepBits'(1);
      end

      if (dec_ctrl.flags_load) begin
        carry_d = bus.alu_carry;
        zero_d  = bus.alu_zero;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // Control lines are silenced whenever the sequencer is not running
  always_comb begin
    out_ctrl = CTRL_NONE;
    if (run) begin
      out_ctrl = dec_ctrl;
    end
  end

  assign bus.pc_out     = out_ctrl.pc_out;
  assign bus.pc_inc     = out_ctrl.pc_inc;
  assign bus.pc_load    = out_ctrl.pc_load;
  assign bus.mar_load   = out_ctrl.mar_load;
  assign bus.ram_out    = out_ctrl.ram_out;
  assign bus.ram_in     = out_ctrl.ram_in;
  assign bus.ir_load    = out_ctrl.ir_load;
  assign bus.ir_out     = out_ctrl.ir_out;
  assign bus.a_load     = out_ctrl.a_load;
  assign bus.a_out      = out_ctrl.a_out;
  assign bus.b_load     = out_ctrl.b_load;
  assign bus.alu_out    = out_ctrl.alu_out;
  assign bus.alu_op     = out_ctrl.alu_op;
  assign bus.out_load   = out_ctrl.out_load;
  assign bus.flag_carry = carry_q;
  assign bus.flag_zero  = zero_q;
  assign bus.halted     = halted_q;
  assign bus.step       = step_q;

endmodule : cpu_control_unit

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit. Two instances share stimulus: one
// treats undefined opcodes as NOP, the other as HLT. Expected per-cycle
// outputs are queued by the stimulus and compared by a monitor at negedge.
module tb_cpu_control_unit;

  typedef struct packed {
    logic [14:0] ctl;
    logic [2:0]  step;
    logic        halted;
    logic        fc;
    logic        fz;
  } exp_t;

  localparam logic [14:0] NONE  = 15'h0000;
  localparam logic [14:0] PCO   = 15'h4000;
  localparam logic [14:0] PCI   = 15'h2000;
  localparam logic [14:0] PCL   = 15'h1000;
  localparam logic [14:0] MARL  = 15'h0800;
  localparam logic [14:0] RAMO  = 15'h0400;
  localparam logic [14:0] RAMI  = 15'h0200;
  localparam logic [14:0] IRL   = 15'h0100;
  localparam logic [14:0] IRO   = 15'h0080;
  localparam logic [14:0] AL    = 15'h0040;
  localparam logic [14:0] AO    = 15'h0020;
  localparam logic [14:0] BL    = 15'h0010;
  localparam logic [14:0] ALUO  = 15'h0008;
  localparam logic [14:0] OUTL  = 15'h0004;
  localparam logic [14:0] OPSUB = 15'h0001;
  localparam logic [14:0] OPSLL = 15'h0002;
  localparam logic [14:0] OPSRL = 15'h0003;
  localparam logic [14:0] F0    = PCO | MARL;
  localparam logic [14:0] F1    = RAMO | IRL | PCI;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_control_unit_if #(.StepBits(3)) bus0 ();
  cpu_control_unit_if #(.StepBits(3)) bus1 ();

  cpu_control_unit #(.StepBits(3), .HaltOnUndefined(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  cpu_control_unit #(.StepBits(3), .HaltOnUndefined(1'b1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  exp_t act0, act1;
  assign act0 = {bus0.pc_out, bus0.pc_inc, bus0.pc_load, bus0.mar_load,
                 bus0.ram_out, bus0.ram_in, bus0.ir_load, bus0.ir_out,
                 bus0.a_load, bus0.a_out, bus0.b_load, bus0.alu_out,
                 bus0.out_load, bus0.alu_op, bus0.step, bus0.halted,
                 bus0.flag_carry, bus0.flag_zero};
  assign act1 = {bus1.pc_out, bus1.pc_inc, bus1.pc_load, bus1.mar_load,
                 bus1.ram_out, bus1.ram_in, bus1.ir_load, bus1.ir_out,
                 bus1.a_load, bus1.a_out, bus1.b_load, bus1.alu_out,
                 bus1.out_load, bus1.alu_op, bus1.step, bus1.halted,
                 bus1.flag_carry, bus1.flag_zero};

  exp_t  q0[$];
  exp_t  q1[$];
  string tq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic exp_t E(input logic [14:0] ctl, input int st,
                             input logic h, input logic c, input logic z);
    E = {ctl, 3'(st), h, c, z};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during it
  task automatic cyc2(input string name, input logic rst, input logic en,
                      input logic [3:0] op, input logic c, input logic z,
                      input exp_t e0, input exp_t e1);
    reset          = rst;
    bus0.enable    = en;
    bus1.enable    = en;
    bus0.opcode    = op;
    bus1.opcode    = op;
    bus0.alu_carry = c;
    bus1.alu_carry = c;
    bus0.alu_zero  = z;
    bus1.alu_zero  = z;
    q0.push_back(e0);
    q1.push_back(e1);
    tq.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic rst, input logic en,
                     input logic [3:0] op, input logic c, input logic z,
                     input exp_t e);
    cyc2(name, rst, en, op, c, z, e, e);
  endtask

  // Monitor: compare DUT outputs against the queued expectations
  initial begin : monitor
    exp_t  e0, e1;
    string nm;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        nm = tq.pop_front();
        n_checks++;
        if (act0 !== e0) begin
          n_fail++;
          $display("FAIL %s nop-variant: got ctl=%b step=%0d halted=%b c=%b z=%b, expected ctl=%b step=%0d halted=%b c=%b z=%b",
                   nm, act0.ctl, act0.step, act0.halted, act0.fc, act0.fz,
                   e0.ctl, e0.step, e0.halted, e0.fc, e0.fz);
        end
        n_checks++;
        if (act1 !== e1) begin
          n_fail++;
          $display("FAIL %s hlt-variant: got ctl=%b step=%0d halted=%b c=%b z=%b, expected ctl=%b step=%0d halted=%b c=%b z=%b",
                   nm, act1.ctl, act1.step, act1.halted, act1.fc, act1.fz,
                   e1.ctl, e1.step, e1.halted, e1.fc, e1.fz);
        end
      end
    end
  end

  initial begin : stimulus
    reset          = 1'b1;
    bus0.enable    = 1'b1;
    bus1.enable    = 1'b1;
    bus0.opcode    = 4'd5;
    bus1.opcode    = 4'd5;
    bus0.alu_carry = 1'b0;
    bus1.alu_carry = 1'b0;
    bus0.alu_zero  = 1'b0;
    bus1.alu_zero  = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds everything at zero
    cyc("reset0", 1, 1, 4'd5, 0, 0, E(NONE, 0, 0, 0, 0));
    cyc("reset1", 1, 1, 4'd5, 1, 1, E(NONE, 0, 0, 0, 0));

    // LDI: three T-states then back to fetch
    cyc("ldi_t0", 0, 1, 4'd5, 0, 0, E(F0, 0, 0, 0, 0));
    cyc("ldi_t1", 0, 1, 4'd5, 0, 0, E(F1, 1, 0, 0, 0));
    cyc("ldi_t2", 0, 1, 4'd5, 0, 0, E(IRO | AL, 2, 0, 0, 0));

    // ADD with carry=1 zero=1 at T4
    cyc("add_t0", 0, 1, 4'd2, 1, 1, E(F0, 0, 0, 0, 0));
    cyc("add_t1", 0, 1, 4'd2, 1, 1, E(F1, 1, 0, 0, 0));
    cyc("add_t2", 0, 1, 4'd2, 1, 1, E(IRO | MARL, 2, 0, 0, 0));
    cyc("add_t3", 0, 1, 4'd2, 1, 1, E(RAMO | BL, 3, 0, 0, 0));
    cyc("add_t4", 0, 1, 4'd2, 1, 1, E(ALUO | AL, 4, 0, 0, 0));

    // SUB leaves carry=1 zero=0
    cyc("sub_t0", 0, 1, 4'd3, 1, 0, E(F0, 0, 0, 1, 1));
    cyc("sub_t1", 0, 1, 4'd3, 1, 0, E(F1, 1, 0, 1, 1));
    cyc("sub_t2", 0, 1, 4'd3, 1, 0, E(IRO | MARL, 2, 0, 1, 1));
    cyc("sub_t3", 0, 1, 4'd3, 1, 0, E(RAMO | BL, 3, 0, 1, 1));
    cyc("sub_t4", 0, 1, 4'd3, 1, 0, E(ALUO | AL | OPSUB, 4, 0, 1, 1));

    // JC taken, JZ not taken with C=1 Z=0
    cyc("jc_t0", 0, 1, 4'd7, 0, 0, E(F0, 0, 0, 1, 0));
    cyc("jc_t1", 0, 1, 4'd7, 0, 0, E(F1, 1, 0, 1, 0));
    cyc("jc_t2", 0, 1, 4'd7, 0, 0, E(IRO | PCL, 2, 0, 1, 0));
    cyc("jz_t0", 0, 1, 4'd8, 0, 0, E(F0, 0, 0, 1, 0));
    cyc("jz_t1", 0, 1, 4'd8, 0, 0, E(F1, 1, 0, 1, 0));
    cyc("jz_t2", 0, 1, 4'd8, 0, 0, E(IRO, 2, 0, 1, 0));

    // SHL sets C=0 Z=1; following JZ taken, JC not taken
    cyc("shl_t0", 0, 1, 4'd9, 0, 1, E(F0, 0, 0, 1, 0));
    cyc("shl_t1", 0, 1, 4'd9, 0, 1, E(F1, 1, 0, 1, 0));
    cyc("shl_t2", 0, 1, 4'd9, 0, 1, E(ALUO | AL | OPSLL, 2, 0, 1, 0));
    cyc("jz2_t0", 0, 1, 4'd8, 1, 0, E(F0, 0, 0, 0, 1));
    cyc("jz2_t1", 0, 1, 4'd8, 1, 0, E(F1, 1, 0, 0, 1));
    cyc("jz2_t2", 0, 1, 4'd8, 1, 0, E(IRO | PCL, 2, 0, 0, 1));
    cyc("jc2_t0", 0, 1, 4'd7, 1, 0, E(F0, 0, 0, 0, 1));
    cyc("jc2_t1", 0, 1, 4'd7, 1, 0, E(F1, 1, 0, 0, 1));
    cyc("jc2_t2", 0, 1, 4'd7, 1, 0, E(IRO, 2, 0, 0, 1));

    // SHR sets C=1 Z=1
    cyc("shr_t0", 0, 1, 4'd10, 1, 1, E(F0, 0, 0, 0, 1));
    cyc("shr_t1", 0, 1, 4'd10, 1, 1, E(F1, 1, 0, 0, 1));
    cyc("shr_t2", 0, 1, 4'd10, 1, 1, E(ALUO | AL | OPSRL, 2, 0, 0, 1));

    // STA, OUT, JMP, NOP, LDA
    cyc("sta_t0", 0, 1, 4'd4, 0, 0, E(F0, 0, 0, 1, 1));
    cyc("sta_t1", 0, 1, 4'd4, 0, 0, E(F1, 1, 0, 1, 1));
    cyc("sta_t2", 0, 1, 4'd4, 0, 0, E(IRO | MARL, 2, 0, 1, 1));
    cyc("sta_t3", 0, 1, 4'd4, 0, 0, E(AO | RAMI, 3, 0, 1, 1));
    cyc("out_t0", 0, 1, 4'd14, 0, 0, E(F0, 0, 0, 1, 1));
    cyc("out_t1", 0, 1, 4'd14, 0, 0, E(F1, 1, 0, 1, 1));
    cyc("out_t2", 0, 1, 4'd14, 0, 0, E(AO | OUTL, 2, 0, 1, 1));
    cyc("jmp_t0", 0, 1, 4'd6, 0, 0, E(F0, 0, 0, 1, 1));
    cyc("jmp_t1", 0, 1, 4'd6, 0, 0, E(F1, 1, 0, 1, 1));
    cyc("jmp_t2", 0, 1, 4'd6, 0, 0, E(IRO | PCL, 2, 0, 1, 1));
    cyc("nop_t0", 0, 1, 4'd0, 0, 0, E(F0, 0, 0, 1, 1));
    cyc("nop_t1", 0, 1, 4'd0, 0, 0, E(F1, 1, 0, 1, 1));
    cyc("nop_t2", 0, 1, 4'd0, 0, 0, E(NONE, 2, 0, 1, 1));
    cyc("lda_t0", 0, 1, 4'd1, 0, 0, E(F0, 0, 0, 1, 1));
    cyc("lda_t1", 0, 1, 4'd1, 0, 0, E(F1, 1, 0, 1, 1));
    cyc("lda_t2", 0, 1, 4'd1, 0, 0, E(IRO | MARL, 2, 0, 1, 1));
    cyc("lda_t3", 0, 1, 4'd1, 0, 0, E(RAMO | AL, 3, 0, 1, 1));

    // ADD with enable dropped at T3 and at T4
    cyc("adde_t0", 0, 1, 4'd2, 0, 0, E(F0, 0, 0, 1, 1));
    cyc("adde_t1", 0, 1, 4'd2, 0, 0, E(F1, 1, 0, 1, 1));
    cyc("adde_t2", 0, 1, 4'd2, 0, 0, E(IRO | MARL, 2, 0, 1, 1));
    for (int i = 0; i < 4; i++)
      cyc("adde_hold3", 0, 0, 4'd2, 0, 0, E(NONE, 3, 0, 1, 1));
    cyc("adde_t3", 0, 1, 4'd2, 0, 0, E(RAMO | BL, 3, 0, 1, 1));
    cyc("adde_hold4", 0, 0, 4'd2, 1, 1, E(NONE, 4, 0, 1, 1));
    cyc("adde_t4", 0, 1, 4'd2, 0, 0, E(ALUO | AL, 4, 0, 1, 1));

    // SHR sets C=1 Z=0, then SUB abandoned by reset at T3
    cyc("shr2_t0", 0, 1, 4'd10, 1, 0, E(F0, 0, 0, 0, 0));
    cyc("shr2_t1", 0, 1, 4'd10, 1, 0, E(F1, 1, 0, 0, 0));
    cyc("shr2_t2", 0, 1, 4'd10, 1, 0, E(ALUO | AL | OPSRL, 2, 0, 0, 0));
    cyc("subr_t0", 0, 1, 4'd3, 1, 1, E(F0, 0, 0, 1, 0));
    cyc("subr_t1", 0, 1, 4'd3, 1, 1, E(F1, 1, 0, 1, 0));
    cyc("subr_t2", 0, 1, 4'd3, 1, 1, E(IRO | MARL, 2, 0, 1, 0));
    cyc("subr_rst", 1, 1, 4'd3, 1, 1, E(NONE, 3, 0, 1, 0));

    // Undefined opcode 12: NOP in one variant, HLT in the other
    cyc("u12_t0", 0, 1, 4'd12, 1, 1, E(F0, 0, 0, 0, 0));
    cyc("u12_t1", 0, 1, 4'd12, 1, 1, E(F1, 1, 0, 0, 0));
    cyc("u12_t2", 0, 1, 4'd12, 1, 1, E(NONE, 2, 0, 0, 0));

    // HLT in the NOP variant; the other is already halted
    cyc2("hlt_t0", 0, 1, 4'd15, 0, 0, E(F0, 0, 0, 0, 0), E(NONE, 0, 1, 0, 0));
    cyc2("hlt_t1", 0, 1, 4'd15, 0, 0, E(F1, 1, 0, 0, 0), E(NONE, 0, 1, 0, 0));
    cyc2("hlt_t2", 0, 1, 4'd15, 0, 0, E(NONE, 2, 0, 0, 0), E(NONE, 0, 1, 0, 0));
    for (int i = 0; i < 20; i++)
      cyc("halted", 0, 1, 4'(i), 1, 1, E(NONE, 0, 1, 0, 0));

    // Reset is the only way out of halt
    cyc("hlt_rst", 1, 1, 4'd5, 0, 0, E(NONE, 0, 1, 0, 0));
    cyc("post_t0", 0, 1, 4'd5, 0, 0, E(F0, 0, 0, 0, 0));
    cyc("post_t1", 0, 1, 4'd5, 0, 0, E(F1, 1, 0, 0, 0));
    cyc("post_t2", 0, 1, 4'd5, 0, 0, E(IRO | AL, 2, 0, 0, 0));
    cyc("post_wrap", 0, 1, 4'd5, 0, 0, E(F0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q0.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cpu_control_unit
